// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/load/decode/write-back controller that turns MIPS R-type words
// from a 1-cycle synchronous RAM into register-file and ALU controls.
module inst_sequencer #(
    parameter int          ADDR_W   = 6,
    parameter logic [5:0]  HALT_OP  = 6'h3F,
    parameter int unsigned START_PC = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [31:0]       Inst_Data,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic [4:0]        R_Addr_A,
    output logic [4:0]        R_Addr_B,
    output logic [4:0]        W_Addr,
    output logic [2:0]        ALU_OP,
    output logic              Write_Reg,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       inst_cnt
);

    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_PC);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] ir;

    // Returns {legal, alu_op} for an R-type funct field.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] res;
        res = 4'b0_000;
        case (funct)
            6'h24:   res = 4'b1_000;
            6'h25:   res = 4'b1_001;
            6'h26:   res = 4'b1_010;
            6'h27:   res = 4'b1_011;
            6'h20:   res = 4'b1_100;
            6'h22:   res = 4'b1_101;
            6'h2A:   res = 4'b1_110;
            6'h04:   res = 4'b1_111;
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

    logic [3:0] dec;
    logic       word_legal;
    logic       unused_shamt;

    assign dec          = decode_funct(ir[5:0]);
    assign word_legal   = (ir[31:26] == 6'd0) && dec[3];
    assign unused_shamt = ^ir[10:6];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            Inst_Addr <= START_ADDR;
            R_Addr_A  <= '0;
            R_Addr_B  <= '0;
            W_Addr    <= '0;
            ALU_OP    <= 3'd0;
            Write_Reg <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            inst_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state     <= S_FETCH;
                        Inst_Addr <= START_ADDR;
                        inst_cnt  <= '0;
                        illegal   <= 1'b0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                // RAM samples Inst_Addr at the end of this cycle.
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    ir    <= Inst_Data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (ir[31:26] == HALT_OP) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        // Operand and write addresses stay put through WB so the ALU result settles early.
                        state    <= S_WB;
                        R_Addr_A <= ir[25:21];
                        R_Addr_B <= ir[20:16];
                        W_Addr   <= ir[15:11];
                        if (word_legal) begin
                            ALU_OP    <= dec[2:0];
                            Write_Reg <= 1'b1;
                        end else begin
                            ALU_OP  <= 3'd0;
                            illegal <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    state     <= S_FETCH;
                    Write_Reg <= 1'b0;
                    Inst_Addr <= Inst_Addr + PC_STEP;
                    inst_cnt  <= inst_cnt + 16'd1;
                end
                default: begin
                    state     <= S_IDLE;
                    Write_Reg <= 1'b0;
                    busy      <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with a behavioural 1-cycle synchronous RAM.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] ram_q;
    logic [5:0]  Inst_Addr;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic [2:0]  ALU_OP;
    logic        Write_Reg;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] inst_cnt;

    logic [31:0] ram [0:63];
    logic [2:0]  op_log [0:15];
    logic [5:0]  fn_tab [0:7];
    int          wr_pulses = 0;
    int          errors;
    int          checks;
    int          base;
    int          drops;
    logic [5:0]  addr63;

    localparam logic [31:0] ADD_W  = 32'h0022_1820;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    inst_sequencer dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .Inst_Data (ram_q),
        .Inst_Addr (Inst_Addr),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .ALU_OP    (ALU_OP),
        .Write_Reg (Write_Reg),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal),
        .inst_cnt  (inst_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= ram[Inst_Addr];

    always @(negedge clk) begin
        if (Write_Reg === 1'b1) begin
            op_log[wr_pulses % 16] = ALU_OP;
            wr_pulses = wr_pulses + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {20'd0, Inst_Addr, R_Addr_A, R_Addr_B, W_Addr, ALU_OP,
                Write_Reg, busy, halted, illegal, inst_cnt};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b0;
        start  = 1'b0;
        fn_tab = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h04};
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        for (int i = 0; i < 16; i++) op_log[i] = 3'd0;

        step(2);
        chk("reset_outputs", all_outs(), 64'd0);
        Reset = 1'b1;
        step(1);

        // Reset asserted during LOAD clears everything without waiting for a clock edge.
        ram[0] = ADD_W;
        ram[1] = HALT_W;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("t1_busy_in_load", busy, 1);
        #1 Reset = 1'b0;
        #1 chk("t1_async_reset", all_outs(), 64'd0);
        Reset = 1'b1;
        step(2);
        chk("t1_stays_idle", {busy, halted}, 2'b00);

        // Single add followed by halt.
        base = wr_pulses;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t2_fetch_busy", busy, 1);
        chk("t2_fetch_addr", Inst_Addr, 0);
        step(2);
        chk("t2_decode_nowrite", Write_Reg, 0);
        step(1);
        chk("t2_wb_write", Write_Reg, 1);
        chk("t2_wb_waddr", W_Addr, 3);
        chk("t2_wb_aluop", ALU_OP, 4);
        chk("t2_wb_ra", R_Addr_A, 1);
        chk("t2_wb_rb", R_Addr_B, 2);
        step(1);
        chk("t2_fetch2_nowrite", Write_Reg, 0);
        chk("t2_fetch2_addr", Inst_Addr, 1);
        chk("t2_fetch2_cnt", inst_cnt, 1);
        step(3);
        chk("t2_halted", halted, 1);
        chk("t2_halt_notbusy", busy, 0);
        chk("t2_halt_cnt", inst_cnt, 1);
        chk("t2_halt_addr", Inst_Addr, 1);
        chk("t2_pulses", wr_pulses - base, 1);

        // Sweep the eight legal functs.
        for (int i = 0; i < 8; i++) ram[i] = mk_r(5'(i + 1), 5'(i + 2), 5'(i + 3), fn_tab[i]);
        ram[8] = HALT_W;
        base = wr_pulses;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(35);
        chk("t3_halted", halted, 1);
        chk("t3_cnt", inst_cnt, 8);
        chk("t3_pulses", wr_pulses - base, 8);
        chk("t3_not_illegal", illegal, 0);
        chk("t3_addr", Inst_Addr, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_aluop_%0d", k), op_log[(base + k) % 16], 64'(k));

        // Undecodable funct, then nonzero non-halt opcode.
        ram[0] = 32'h0000_003F;
        ram[1] = HALT_W;
        base = wr_pulses;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("t4_wb_nowrite", Write_Reg, 0);
        chk("t4_wb_illegal", illegal, 1);
        step(4);
        chk("t4_halted", halted, 1);
        chk("t4_cnt", inst_cnt, 1);
        chk("t4_sticky", illegal, 1);
        chk("t4_pulses", wr_pulses - base, 0);
        ram[0] = 32'h0822_1820;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t4_start_clears_illegal", illegal, 0);
        chk("t4_start_clears_cnt", inst_cnt, 0);
        step(7);
        chk("t4_op_halted", halted, 1);
        chk("t4_op_illegal", illegal, 1);
        chk("t4_op_cnt", inst_cnt, 1);
        chk("t4_op_pulses", wr_pulses - base, 0);

        // start while busy is ignored; start held high restarts from HALT.
        ram[0] = ADD_W;
        ram[1] = HALT_W;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t6_ignore_write", Write_Reg, 1);
        chk("t6_ignore_busy", busy, 1);
        step(1);
        chk("t6_ignore_addr", Inst_Addr, 1);
        step(3);
        chk("t6_halted", halted, 1);
        start = 1'b1;
        step(1);
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_addr", Inst_Addr, 0);
        chk("t6_restart_cnt", inst_cnt, 0);
        step(7);
        chk("t6_halt_wins", halted, 1);
        chk("t6_halt_wins_cnt", inst_cnt, 1);
        step(1);
        chk("t6_rerestart_addr", Inst_Addr, 0);
        chk("t6_rerestart_busy", busy, 1);
        start = 1'b0;
        step(7);
        chk("t6_final_halt", halted, 1);

        // Sixty-four legal words, no halt: PC wraps and the block never leaves busy.
        for (int i = 0; i < 64; i++) ram[i] = ADD_W;
        base = wr_pulses;
        drops = 0;
        addr63 = 6'd0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (busy !== 1'b1) drops++;
            if (i == 251) addr63 = Inst_Addr;
        end
        chk("t5_addr63", addr63, 63);
        chk("t5_wrap_addr", Inst_Addr, 0);
        chk("t5_cnt", inst_cnt, 64);
        chk("t5_busy_drops", drops, 0);
        chk("t5_pulses", wr_pulses - base, 64);
        step(2);
        #1 Reset = 1'b0;
        #1 chk("t5_midrun_reset", all_outs(), 64'd0);
        Reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
